// File: rtl/seq_array_multiplier.sv
// Iterative sign/magnitude multiplier: BITS_PER_CYCLE partial-product rows per cycle,
// valid/ready handshakes on input and output.
module seq_array_multiplier #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] ma_sh, acc, row, p_q;
  logic               neg;
  logic [CW-1:0]      count;

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    row = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mb[j]) row = row + (ma_sh << j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (count == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_sh <= '0;
      mb    <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      count <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ma_sh <= {{WIDTH{1'b0}}, mag_a};
          mb    <= mag_b;
          neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc   <= '0;
          count <= '0;
        end
        BUSY: begin
          // count==LAST is the fix-up step that applies the sign to the magnitude product.
          if (count == LAST) begin
            p_q <= neg ? (~acc + 1'b1) : acc;
          end else begin
            acc   <= acc + row;
            ma_sh <= ma_sh << BITS_PER_CYCLE;
            mb    <= mb >> BITS_PER_CYCLE;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Scoreboard bench for seq_array_multiplier: an 8x8 BPC=1 instance (dut 0) and an
// 8x8 BPC=2 instance (dut 1) exercised in turn.
module tb_seq_array_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic        is_signed[2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [7:0]  a [2];
  logic [7:0]  b [2];
  logic [15:0] p [2];

  typedef struct {
    int          dut;
    logic [15:0] prod;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = -1;
  bit   chk_space = 1'b0;
  bit   vprev[2] = '{1'b0, 1'b0};
  int   lat_req[2] = '{9, 5};

  seq_array_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .is_signed(is_signed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .p(p[0]));

  seq_array_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .is_signed(is_signed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .p(p[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] xs, ys;
    if (s) begin
      xs = {{8{x[7]}}, x};
      ys = {{8{y[7]}}, y};
      return xs * ys;
    end
    return {8'h00, x} * {8'h00, y};
  endfunction

  // Called just after a negedge; returns on the negedge following the accept edge.
  task automatic send(input int k, input logic [7:0] av, input logic [7:0] bv,
                      input logic s, input logic [15:0] ex);
    int n = 0;
    a[k] = av; b[k] = bv; is_signed[k] = s; in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      check("accept_timeout", 32'(in_ready[k]), 32'd1);
      in_valid[k] = 1'b0;
      return;
    end
    q.push_back('{dut: k, prod: ex, acc: cyc + 1});
    // accept, ITER busy edges, fix-up, consume, then accept again: ITER+3 edges apart
    if (chk_space && last_acc >= 0) check("accept_spacing", 32'(cyc + 1 - last_acc), 32'd7);
    last_acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (out_valid[k] && !vprev[k]) begin
        if (q.size() == 0 || q[0].dut != k) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output dut%0d: got out_valid=1 p=0x%0h, required no output", k, p[k]);
        end else begin
          check($sformatf("latency_dut%0d", k), 32'(cyc - q[0].acc), 32'(lat_req[k]));
        end
      end
      if (out_valid[k] && out_ready[k] && q.size() != 0 && q[0].dut == k) begin
        mon_e = q.pop_front();
        check($sformatf("product_dut%0d", k), 32'(p[k]), 32'(mon_e.prod));
      end
      vprev[k] = out_valid[k];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; is_signed[k] = 1'b0; out_ready[k] = 1'b0;
      a[k] = '0; b[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_in_ready_dut%0d", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("reset_out_valid_dut%0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset_p_dut%0d", k), 32'(p[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    out_ready[0] = 1'b1;
    send(0, 8'd13,  8'd11,  1'b0, 16'h008F);
    send(0, 8'hFF,  8'hFF,  1'b0, 16'hFE01);
    send(0, 8'h00,  8'hAB,  1'b0, 16'h0000);
    send(0, 8'hFD,  8'h05,  1'b1, 16'hFFF1);
    send(0, 8'h80,  8'h80,  1'b1, 16'h4000);
    send(0, 8'h80,  8'h7F,  1'b1, 16'hC080);
    send(0, 8'hFF,  8'hFF,  1'b1, 16'h0001);
    in_valid[0] = 1'b0;
    drain();

    // backpressure
    out_ready[0] = 1'b0;
    send(0, 8'h80, 8'h7F, 1'b1, 16'hC080);
    in_valid[0] = 1'b0;
    for (int n = 0; n < 50 && !out_valid[0]; n++) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_p_held", 32'(p[0]), 32'hC080);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      if (i == 2) begin
        in_valid[0] = 1'b1; a[0] = 8'd3; b[0] = 8'd3; is_signed[0] = 1'b0;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    check("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    drain();

    // reset during the 4th BUSY cycle aborts silently
    send(0, 8'h55, 8'h33, 1'b0, 16'h10EF);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(q.pop_back());
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_p", 32'(p[0]), 32'd0);
    repeat (15) @(negedge clk);
    send(0, 8'd7, 8'd6, 1'b0, 16'h002A);
    in_valid[0] = 1'b0;
    drain();

    // BPC=2: in_valid held high, out_ready high, accepts back to back
    out_ready[1] = 1'b1;
    chk_space = 1'b1;
    last_acc = -1;
    send(1, 8'd13, 8'd11, 1'b0, 16'h008F);
    send(1, 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    send(1, 8'h80, 8'h80, 1'b1, 16'h4000);
    send(1, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    send(1, 8'h80, 8'h7F, 1'b1, 16'hC080);
    for (int i = 0; i < 200; i++) begin
      logic [7:0] x, y;
      logic       s;
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      send(1, x, y, s, ref_mul(x, y, s));
    end
    in_valid[1] = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
